// File: rtl/processor_datapath.sv
// processor_datapath: 10-bit bus, register file, ALU A/G, IR and timestep counter driven by the controller's control word.
module processor_datapath (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Step,
  input  logic [9:0] ExternalData,
  input  logic [9:0] ImmediateValue,
  input  logic [1:0] RegisterToWrite,
  input  logic [1:0] RegisterToRead,
  input  logic       WriteEnable,
  input  logic       ReadEnable,
  input  logic       ALUInputEnable,
  input  logic       ALUOutputEnable,
  input  logic       ALUToBusEnable,
  input  logic [3:0] ALUControl,
  input  logic       ExternalBusEnable,
  input  logic       InstructionRegEnable,
  input  logic       ResetTimestep,
  output logic [9:0] Bus,
  output logic [9:0] Instruction,
  output logic [1:0] CurrentTimestep,
  output logic       BusConflict
);
  logic [9:0] r [4];
  logic [9:0] a, g, ir, f;
  logic [1:0] ts;
  logic       conflict, multi;
  assign Bus = ExternalBusEnable ? ExternalData :
               ReadEnable        ? r[RegisterToRead] :
               ALUToBusEnable    ? g : ImmediateValue;
  assign multi = (ExternalBusEnable & ReadEnable) | (ExternalBusEnable & ALUToBusEnable) |
                 (ReadEnable & ALUToBusEnable);
  assign Instruction = ir;
  assign CurrentTimestep = ts;
  assign BusConflict = conflict;
  always_comb begin
    f = '0;
    case (ALUControl)
      4'b0000: f = a + Bus;
      4'b0001: f = a - Bus;
      4'b0010: f = a & Bus;
      4'b0011: f = a | Bus;
      4'b0100: f = a ^ Bus;
      4'b0101: f = ~a;
      4'b0110: f = {a[8:0], 1'b0};
      4'b0111: f = {1'b0, a[9:1]};
      4'b1000: f = Bus;
      4'b1001: f = a + 10'd1;
      4'b1010: f = a - 10'd1;
      default: f = '0;
    endcase
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r        <= '{default: '0};
      a        <= '0;
      g        <= '0;
      ir       <= '0;
      ts       <= '0;
      conflict <= 1'b0;
    end else begin
      if (WriteEnable) r[RegisterToWrite] <= Bus;
      if (ALUInputEnable) a <= Bus;
      if (ALUOutputEnable) g <= f;
      if (InstructionRegEnable) ir <= Bus;
      if (ResetTimestep) ts <= '0;
      else if (Step) ts <= ts + 2'd1;
      if (multi) conflict <= 1'b1;
    end
  end
endmodule

// File: tb/tb_processor_datapath.sv
// tb_processor_datapath: directed vectors with a queued scoreboard checked by a negedge monitor.
module tb_processor_datapath;
  logic       Clock = 0, Reset, Step;
  logic [9:0] ExternalData, ImmediateValue;
  logic [1:0] RegisterToWrite, RegisterToRead;
  logic       WriteEnable, ReadEnable, ALUInputEnable, ALUOutputEnable, ALUToBusEnable;
  logic [3:0] ALUControl;
  logic       ExternalBusEnable, InstructionRegEnable, ResetTimestep;
  logic [9:0] Bus, Instruction;
  logic [1:0] CurrentTimestep;
  logic       BusConflict;

  processor_datapath dut (
    .Clock(Clock), .Reset(Reset), .Step(Step), .ExternalData(ExternalData),
    .ImmediateValue(ImmediateValue), .RegisterToWrite(RegisterToWrite),
    .RegisterToRead(RegisterToRead), .WriteEnable(WriteEnable), .ReadEnable(ReadEnable),
    .ALUInputEnable(ALUInputEnable), .ALUOutputEnable(ALUOutputEnable),
    .ALUToBusEnable(ALUToBusEnable), .ALUControl(ALUControl),
    .ExternalBusEnable(ExternalBusEnable), .InstructionRegEnable(InstructionRegEnable),
    .ResetTimestep(ResetTimestep), .Bus(Bus), .Instruction(Instruction),
    .CurrentTimestep(CurrentTimestep), .BusConflict(BusConflict)
  );

  always #5 Clock = ~Clock;

  localparam int BUS = 0, IR = 1, TS = 2, CONF = 3;
  typedef struct {
    int         due;
    int         sel;
    logic [9:0] exp;
    string      name;
  } item_t;
  item_t sb[$];
  int cyc = 0, checks = 0, failures = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        logic [9:0] act;
        act = sb[i].sel == BUS ? Bus : sb[i].sel == IR ? Instruction :
              sb[i].sel == TS ? {8'd0, CurrentTimestep} : {9'd0, BusConflict};
        checks++;
        if (act !== sb[i].exp) begin
          failures++;
          $display("FAIL %s: got 0x%03h expected 0x%03h", sb[i].name, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic chk(input int sel, input logic [9:0] e, input string n);
    item_t it;
    it.due = cyc; it.sel = sel; it.exp = e; it.name = n;
    sb.push_back(it);
  endtask

  task automatic idle();
    Reset = 0; Step = 0; WriteEnable = 0; ReadEnable = 0; ALUInputEnable = 0;
    ALUOutputEnable = 0; ALUToBusEnable = 0; ExternalBusEnable = 0;
    InstructionRegEnable = 0; ResetTimestep = 0; ALUControl = 4'd0;
    RegisterToWrite = 2'd0; RegisterToRead = 2'd0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  logic [9:0] sweep [16];
  logic [1:0] ts_seq [5];

  initial begin
    sweep = '{10'h19A, 10'h046, 10'h0A0, 10'h0FA, 10'h05A, 10'h30F, 10'h1E0, 10'h078,
              10'h0AA, 10'h0F1, 10'h0EF, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000};
    ts_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    idle();
    ExternalData = '0; ImmediateValue = '0;
    Reset = 1; tick();
    // preload R2, G and timestep, then reset with a write pending
    ImmediateValue = 10'h155; WriteEnable = 1; RegisterToWrite = 2; tick();
    ImmediateValue = 10'h3FF; ALUControl = 4'b1000; ALUOutputEnable = 1; Step = 1; tick();
    Step = 1; tick();
    ReadEnable = 1; RegisterToRead = 2; chk(BUS, 10'h155, "pre_r2"); chk(TS, 10'd2, "pre_ts"); tick();
    ALUToBusEnable = 1; chk(BUS, 10'h3FF, "pre_g");
    Reset = 1; WriteEnable = 1; RegisterToWrite = 2; Step = 1; tick();
    ImmediateValue = 10'h123;
    chk(BUS, 10'h123, "rst_bus"); chk(IR, 10'h000, "rst_ir");
    chk(TS, 10'h000, "rst_ts"); chk(CONF, 10'h000, "rst_conf"); tick();
    ReadEnable = 1; RegisterToRead = 2; chk(BUS, 10'h000, "rst_r2"); tick();
    ALUToBusEnable = 1; chk(BUS, 10'h000, "rst_g"); tick();
    ALUControl = 4'b1001; ALUOutputEnable = 1; tick();
    ALUToBusEnable = 1; chk(BUS, 10'h001, "rst_a"); tick();
    // load and move
    ExternalData = 10'h2A5; ExternalBusEnable = 1; WriteEnable = 1; RegisterToWrite = 1;
    chk(BUS, 10'h2A5, "ext_bus"); tick();
    ReadEnable = 1; RegisterToRead = 1; WriteEnable = 1; RegisterToWrite = 3;
    chk(BUS, 10'h2A5, "move_bus"); tick();
    ReadEnable = 1; RegisterToRead = 3; WriteEnable = 1; RegisterToWrite = 3;
    chk(BUS, 10'h2A5, "r3"); tick();
    ReadEnable = 1; RegisterToRead = 3; chk(BUS, 10'h2A5, "r3_self"); tick();
    // add with wrap
    ImmediateValue = 10'h3FF; ALUInputEnable = 1; tick();
    ImmediateValue = 10'h002; ALUControl = 4'b0000; ALUOutputEnable = 1; tick();
    ALUToBusEnable = 1; WriteEnable = 1; RegisterToWrite = 0; chk(BUS, 10'h001, "add_wrap"); tick();
    ReadEnable = 1; RegisterToRead = 0; chk(BUS, 10'h001, "r0"); tick();
    // ALU sweep
    ImmediateValue = 10'h0F0; ALUInputEnable = 1; tick();
    for (int k = 0; k < 16; k++) begin
      ImmediateValue = 10'h0AA; ALUControl = 4'(k); ALUOutputEnable = 1; tick();
      ALUToBusEnable = 1; chk(BUS, sweep[k], $sformatf("alu_%0d", k)); tick();
    end
    // G feeding the bus while G is reloaded; A loaded alongside G
    ALUToBusEnable = 1; ALUOutputEnable = 1; ALUControl = 4'b0000; chk(BUS, 10'h000, "g_loop0"); tick();
    ALUToBusEnable = 1; ALUOutputEnable = 1; ALUControl = 4'b0000; chk(BUS, 10'h0F0, "g_loop1"); tick();
    ALUToBusEnable = 1; chk(BUS, 10'h1E0, "g_loop2"); tick();
    ImmediateValue = 10'h005; ALUInputEnable = 1; ALUOutputEnable = 1; ALUControl = 4'b0000; tick();
    ALUToBusEnable = 1; chk(BUS, 10'h0F5, "g_old_a"); tick();
    ALUControl = 4'b1001; ALUOutputEnable = 1; tick();
    ALUToBusEnable = 1; chk(BUS, 10'h006, "a_new"); tick();
    // timestep counter and IR
    ResetTimestep = 1; tick();
    for (int k = 0; k < 5; k++) begin
      Step = 1; tick();
      chk(TS, {8'd0, ts_seq[k]}, $sformatf("ts_%0d", k));
    end
    Step = 1; ResetTimestep = 1; tick();
    chk(TS, 10'd0, "ts_clr");
    ImmediateValue = 10'h1C3; InstructionRegEnable = 1; chk(IR, 10'h000, "ir_before"); tick();
    chk(IR, 10'h1C3, "ir_load");
    // bus conflict is sticky until reset
    chk(CONF, 10'd0, "conf_pre");
    ExternalData = 10'h0CC; ExternalBusEnable = 1; ALUToBusEnable = 1;
    chk(BUS, 10'h0CC, "conf_bus"); tick();
    chk(CONF, 10'd1, "conf_set"); tick(); tick(); tick();
    chk(CONF, 10'd1, "conf_hold");
    Reset = 1; tick();
    chk(CONF, 10'd0, "conf_rst");
    ReadEnable = 1; RegisterToRead = 1; ALUToBusEnable = 1; chk(BUS, 10'h000, "conf_rd_prio"); tick();
    chk(CONF, 10'd1, "conf_rd_alu");
    tick(); tick();
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
